multibyte_add_seq: RTL and testbench
====================================

// Module: multibyte_add_seq
// PURPOSE
//  Sequences the team's 8-bit `adder` block over a BYTES-wide operand, one byte per cycle.
//  The carry between bytes is held in a flop.
//  Provides multi-precision ADD and SUB (SUB = a + ~b + cin; cin=1 means no borrow).
//  Returns result, carry-out, signed overflow and zero.
//  Sits between the ALU control path and the shared 8-bit adder; start/busy/done handshake.
// PARAMETERS
//  BYTES  2  operand width in bytes; legal range 1..8; operand width W = 8*BYTES
// PORTS
//  clk     in   1    single clock, rising edge
//  rst     in   1    asynchronous, active-high reset
//  start   in   1    request; accepted only when busy=0
//  sub     in   1    0 = ADD, 1 = SUB; sampled with start
//  cin     in   1    carry-in to byte 0; sampled with start
//  a       in   W    operand A; sampled with start
//  b       in   W    operand B; sampled with start
//  busy    out  1    high from the cycle after acceptance until done returns low
//  done    out  1    one-cycle pulse; result fields valid from this cycle
//  result  out  W    sum/difference
//  cout    out  1    carry-out of the top byte
//  ovf     out  1    signed overflow of the top byte (W-bit two's-complement overflow)
//  zero    out  1    1 when result == 0
// BEHAVIOUR
//  - Reset, async on rst=1: state IDLE, byte index 0, carry flop 0.
//    Outputs busy=0, done=0, result=0, cout=0, ovf=0, zero=0.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE: on start=1 at edge k, latch a, b (b inverted when sub=1), sub, cin.
//      Carry flop <= cin, idx <= 0, zero-accumulator <= 1, go to RUN.
//    - RUN: adder sees a[8*idx+:8], b'[8*idx+:8] and the carry flop.
//      Each edge: result byte idx <= s, carry flop <= adder cout, zacc <= zacc & (s==0), idx++.
//      At idx == BYTES-1 the edge also latches cout and ovf from the adder and goes to DONE.
//    - DONE: done=1, busy=1 for exactly one cycle, then IDLE.
//  - Latency: start accepted at edge k -> done high in the cycle after edge k+BYTES.
//    Next start is accepted at the earliest at edge k+BYTES+2.
//  - busy = (state != IDLE). start while busy=1 is ignored; it is neither queued nor flagged.
//  - result, cout, ovf and zero update only at RUN edges.
//    They hold their last value in IDLE until the next operation overwrites them.
//    They are valid only when done=1 or later.
//  - BYTES=1: a single RUN cycle. Identical to a direct `adder` use plus the handshake.
//  - Carry chain wraps between bytes only. The top-byte cout/ovf are final; there is no wrap to byte 0.
//  - Operand inputs may change freely after acceptance; the internal copies are used.
//  - rst mid-operation: immediate abort to the reset state. No done pulse; partial result discarded.
//  - sub semantics: cout=1 means no borrow; ovf is computed on A + ~B + cin.
// STRUCTURE
//  - Shared package alu_pkg: state encoding localparams
//    (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the BYTE_W=8 constant.
//  - One sub-module instance: `adder` (8-bit, ports a, b, cin, s, cout, over), used combinationally.
//  - Local logic: state register, idx counter ($clog2(BYTES)+1 bits), carry flop,
//    operand registers, result/flag registers.
// TESTING
//  1. BYTES=2, ADD, a=16'h00FF, b=16'h0001, cin=0
//     -> done after 2 RUN cycles; result=16'h0100, cout=0, ovf=0, zero=0.
//  2. BYTES=2, ADD, a=16'h7FFF, b=16'h0001, cin=0
//     -> result=16'h8000, ovf=1, cout=0.
//     Then a=16'hFFFF, b=16'h0001 -> result=16'h0000, cout=1, zero=1, ovf=0.
//  3. BYTES=2, SUB, a=16'h1000, b=16'h0001, cin=1
//     -> result=16'h0FFF, cout=1 (no borrow).
//     Then a=16'h0000, b=16'h0001, cin=1 -> result=16'hFFFF, cout=0.
//  4. start pulsed again during RUN/DONE with different operands
//     -> ignored; first result correct; busy falls; a new start then proceeds normally.
//  5. rst asserted during RUN (after byte 0)
//     -> outputs zero asynchronously, no done pulse.
//     A start after release gives a correct result.
//  6. BYTES=1 and BYTES=4 random ADD/SUB, 1000 ops
//     -> result/cout/ovf/zero match a W-bit reference model; done exactly BYTES+1 cycles after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared byte width and sequencer state encoding
package alu_pkg;
  localparam int BYTE_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/adder.sv
// adder: 8-bit combinational adder with carry-out and signed overflow
module adder
  import alu_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout,
  output logic              over
);
  // sum with carry; overflow when like-signed operands give a differently signed sum
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    over = (a[BYTE_W-1] == b[BYTE_W-1]) & (s[BYTE_W-1] != a[BYTE_W-1]);
  end
endmodule

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: multi-precision add/sub sequenced one byte per cycle over a shared 8-bit adder
module multibyte_add_seq
  import alu_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sub,
  input  logic                    cin,
  input  logic [BYTE_W*BYTES-1:0] a,
  input  logic [BYTE_W*BYTES-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [BYTE_W*BYTES-1:0] result,
  output logic                    cout,
  output logic                    ovf,
  output logic                    zero
);
  localparam int W = BYTE_W * BYTES;
  localparam int IW = $clog2(BYTES) + 1;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [W-1:0] ra, rb;
  logic carry, zacc, ac, ao, last;
  logic [BYTE_W-1:0] s;
  assign last = idx == IW'(BYTES - 1);
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  adder u_adder (
    .a   (ra[BYTE_W*idx +: BYTE_W]),
    .b   (rb[BYTE_W*idx +: BYTE_W]),
    .cin (carry),
    .s   (s),
    .cout(ac),
    .over(ao)
  );
  // next state: accept in IDLE, run BYTES cycles, single DONE cycle
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
              state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  // operand capture on accept, byte-serial accumulate while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      carry <= 1'b0;
      zacc <= 1'b0;
      ra <= '0;
      rb <= '0;
      result <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (state == S_IDLE && start) begin
      ra <= a;
      rb <= sub ? ~b : b;
      carry <= cin;
      idx <= '0;
      zacc <= 1'b1;
    end else if (state == S_RUN) begin
      result[BYTE_W*idx +: BYTE_W] <= s;
      carry <= ac;
      zacc <= zacc & (s == '0);
      idx <= idx + 1'b1;
      if (last) begin
        cout <= ac;
        ovf <= ao;
        zero <= zacc & (s == '0);
      end
    end
  end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb_multibyte_add_seq: directed and randomized checks of the byte-serial add/sub sequencer
module tb_multibyte_add_seq;
  logic clk = 0, rst = 0;
  logic [2:0] st = '0;
  logic sb = 0, ci = 0;
  logic [31:0] av = '0, bv = '0;
  logic [15:0] r2;
  logic [7:0] r1;
  logic [31:0] r4;
  logic [2:0] bz, dn, co, ov, zr;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  multibyte_add_seq #(.BYTES(2)) dut (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb), .cin(ci), .a(av[15:0]), .b(bv[15:0]),
    .busy(bz[0]), .done(dn[0]), .result(r2), .cout(co[0]), .ovf(ov[0]), .zero(zr[0])
  );
  multibyte_add_seq #(.BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb), .cin(ci), .a(av[7:0]), .b(bv[7:0]),
    .busy(bz[1]), .done(dn[1]), .result(r1), .cout(co[1]), .ovf(ov[1]), .zero(zr[1])
  );
  multibyte_add_seq #(.BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb), .cin(ci), .a(av), .b(bv),
    .busy(bz[2]), .done(dn[2]), .result(r4), .cout(co[2]), .ovf(ov[2]), .zero(zr[2])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int nb(input int n);
    return n == 0 ? 2 : n == 1 ? 1 : 4;
  endfunction
  function automatic void model(input int n, input bit s, input bit c, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] er, output logic [2:0] ef);
    int w;
    logic [32:0] m, xx, bb, sum;
    w = 8 * nb(n);
    m = (33'd1 << w) - 33'd1;
    xx = {1'b0, x} & m;
    bb = (s ? ~{1'b0, y} : {1'b0, y}) & m;
    sum = xx + bb + {32'd0, c};
    er = sum[31:0] & m[31:0];
    ef = {sum[w], (xx[w-1] == bb[w-1]) && (er[w-1] != xx[w-1]), er == 32'd0};
  endfunction
  task automatic t(input int n, input bit s, input bit c, input logic [31:0] x, input logic [31:0] y,
                   input bit poke, input logic [31:0] er, input logic [2:0] ef);
    int lat;
    logic [31:0] res;
    @(negedge clk);
    av = x; bv = y; sb = s; ci = c; st[n] = 1'b1;
    @(posedge clk); #1;
    st[n] = 1'b0; av = ~x; bv = ~y; sb = ~s; ci = ~c;
    chk("busy_after_accept", {31'd0, bz[n]}, 32'd1);
    lat = 0;
    while (!dn[n] && lat < 20) begin
      if (poke) begin
        st[n] = 1'b1;
        av = 32'h1234_5678;
        bv = 32'h0F0F_0F0F;
      end
      @(posedge clk); #1;
      lat++;
    end
    st[n] = 1'b0;
    chk("latency", lat, nb(n));
    chk("busy_in_done", {31'd0, bz[n]}, 32'd1);
    res = n == 0 ? {16'h0, r2} : n == 1 ? {24'h0, r1} : r4;
    chk("result", res, er);
    chk("flags_cout_ovf_zero", {29'd0, co[n], ov[n], zr[n]}, {29'd0, ef});
    @(posedge clk); #1;
    chk("done_single_pulse", {31'd0, dn[n]}, 32'd0);
    chk("busy_fall", {31'd0, bz[n]}, 32'd0);
  endtask
  initial begin
    logic [31:0] er, x, y;
    logic [2:0] ef;
    bit s, c;
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bz[0]}, 32'd0);
    chk("rst_done", {31'd0, dn[0]}, 32'd0);
    chk("rst_result", {16'd0, r2}, 32'd0);
    chk("rst_flags", {29'd0, co[0], ov[0], zr[0]}, 32'd0);
    @(negedge clk) rst = 0;
    t(0, 0, 0, 32'h00FF, 32'h0001, 0, 32'h0100, 3'b000);
    t(0, 0, 0, 32'h7FFF, 32'h0001, 0, 32'h8000, 3'b010);
    t(0, 0, 0, 32'hFFFF, 32'h0001, 0, 32'h0000, 3'b101);
    t(0, 1, 1, 32'h1000, 32'h0001, 0, 32'h0FFF, 3'b100);
    t(0, 1, 1, 32'h0000, 32'h0001, 0, 32'hFFFF, 3'b000);
    t(0, 0, 0, 32'h1234, 32'h1111, 1, 32'h2345, 3'b000);
    t(0, 0, 1, 32'h0F0F, 32'h00F0, 0, 32'h1000, 3'b000);
    @(negedge clk);
    av = 32'h8000; bv = 32'h8000; sb = 0; ci = 0; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("abort_busy", {31'd0, bz[0]}, 32'd0);
    chk("abort_done", {31'd0, dn[0]}, 32'd0);
    chk("abort_result", {16'd0, r2}, 32'd0);
    chk("abort_flags", {29'd0, co[0], ov[0], zr[0]}, 32'd0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {31'd0, dn[0]}, 32'd0);
    end
    t(0, 0, 0, 32'h8000, 32'h8000, 0, 32'h0000, 3'b111);
    t(1, 0, 0, 32'h7F, 32'h01, 0, 32'h80, 3'b010);
    t(2, 0, 0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 3'b101);
    t(2, 1, 1, 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 3'b110);
    for (int n = 1; n <= 2; n++) begin
      for (int i = 0; i < 1000; i++) begin
        x = $urandom;
        y = $urandom;
        s = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        if (i % 50 == 0) y = s ? x : -x;
        model(n, s, c, x, y, er, ef);
        t(n, s, c, x, y, 0, er, ef);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
